// File: rtl/fb_write_arbiter.sv
// Burst-aware write arbiter multiplexing N draw engines onto the frame buffer write port.
// Define FB_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module fb_write_arbiter #(
    parameter  int NUM_CH    = 4,
    parameter  int ADDR_W    = 17,
    parameter  int DATA_W    = 24,
    parameter  int MAX_BURST = 16,
    localparam int OWN_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_last,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [DATA_W-1:0]        fb_data,
    output logic [OWN_W-1:0]         owner,
    output logic                     busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [OWN_W-1:0]   owner_nxt;
    logic [OWN_W-1:0]   winner;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               sel_req, sel_last;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               transfer;

    assign busy     = (state == GRANT);
    assign transfer = busy & sel_req;
    assign cnt_inc  = cnt + CNT_W'(1);

    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        ch_ack   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = ch_req[i] & (owner == OWN_W'(i)) & busy;
            if (owner == OWN_W'(i)) begin
                sel_req  = ch_req[i];
                sel_last = ch_last[i];
                sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
                sel_data = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef FB_ARB_ROUND_ROBIN_EN
    logic [OWN_W-1:0] rr_ptr;

    // Search upward from the channel after the last winner, wrapping modulo NUM_CH.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = rr_ptr;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!found && ch_req[idx]) begin
                winner = OWN_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= OWN_W'(NUM_CH - 1);
        else if (state == IDLE && |ch_req)
            rr_ptr <= winner;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i])
                winner = OWN_W'(i);
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (|ch_req) begin
                    state_nxt = GRANT;
                    owner_nxt = winner;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (transfer) begin
                    cnt_nxt = cnt_inc;
                    if (sel_last || cnt_inc == CNT_W'(MAX_BURST))
                        state_nxt = IDLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One-cycle write pipeline; address and data hold when no transfer occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= transfer;
            if (transfer) begin
                fb_addr <= sel_addr;
                fb_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter (default NUM_CH=4, MAX_BURST=16).
// Fixed-priority scenarios run by default; the round-robin order check runs with FB_ARB_ROUND_ROBIN_EN.
module tb_fb_write_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 24;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_last;
    logic [NUM_CH-1:0]        ch_ack;
    logic                     fb_we;
    logic [ADDR_W-1:0]        fb_addr;
    logic [DATA_W-1:0]        fb_data;
    logic [1:0]               owner;
    logic                     busy;

    int check_count = 0;
    int error_count = 0;

    fb_write_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_addr(ch_addr),
        .ch_data(ch_data), .ch_last(ch_last), .ch_ack(ch_ack), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_data(fb_data), .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic req, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input logic last);
        ch_req[ch]                  = req;
        ch_addr[ch*ADDR_W +: ADDR_W] = addr;
        ch_data[ch*DATA_W +: DATA_W] = data;
        ch_last[ch]                 = last;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        ch_req  = '0;
        ch_addr = '0;
        ch_data = '0;
        ch_last = '0;
        #2;
        checkOutput("rst_fb_we", 32'(fb_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_ack", 32'(ch_ack), 32'd0);
        checkOutput("rst_addr", 32'(fb_addr), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        $display("[TB] single channel burst");
        applyStimulus(1, 1'b1, 17'h00010, 24'hFF0000, 1'b0);
        #1;
        checkOutput("t1_ack_arb", 32'(ch_ack), 32'd0);
        checkOutput("t1_busy_arb", 32'(busy), 32'd0);
        tick();
        checkOutput("t1_owner", 32'(owner), 32'd1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1'b1, 17'(32'h10 + k), 24'hFF0000, (k == 4));
            #1;
            checkOutput("t1_ack", 32'(ch_ack), 32'b0010);
            tick();
            checkOutput("t1_we", 32'(fb_we), 32'd1);
            checkOutput("t1_addr", 32'(fb_addr), 32'h10 + k);
            checkOutput("t1_data", 32'(fb_data), 32'hFF0000);
        end
        checkOutput("t1_busy_rel", 32'(busy), 32'd0);
        applyStimulus(1, 1'b0, 17'h00014, 24'hFF0000, 1'b0);
        tick();
        checkOutput("t1_we_off", 32'(fb_we), 32'd0);
        checkOutput("t1_addr_hold", 32'(fb_addr), 32'h14);

`ifndef FB_ARB_ROUND_ROBIN_EN
        $display("[TB] fixed priority 0 vs 2");
        applyStimulus(0, 1'b1, 17'h00100, 24'h00AA00, 1'b0);
        applyStimulus(2, 1'b1, 17'h00200, 24'h0000BB, 1'b1);
        #1;
        checkOutput("t2_ack_arb", 32'(ch_ack), 32'd0);
        tick();
        checkOutput("t2_owner0", 32'(owner), 32'd0);
        checkOutput("t2_ack0", 32'(ch_ack), 32'b0001);
        tick();
        checkOutput("t2_addr0", 32'(fb_addr), 32'h100);
        applyStimulus(0, 1'b1, 17'h00101, 24'h00AA00, 1'b1);
        #1;
        checkOutput("t2_ack0b", 32'(ch_ack), 32'b0001);
        tick();
        checkOutput("t2_addr1", 32'(fb_addr), 32'h101);
        checkOutput("t2_busy_rel", 32'(busy), 32'd0);
        applyStimulus(0, 1'b0, 17'h00101, 24'h00AA00, 1'b0);
        #1;
        checkOutput("t2_ack_idle", 32'(ch_ack), 32'd0);
        tick();
        checkOutput("t2_owner2", 32'(owner), 32'd2);
        checkOutput("t2_ack2", 32'(ch_ack), 32'b0100);
        tick();
        checkOutput("t2_addr2", 32'(fb_addr), 32'h200);
        checkOutput("t2_data2", 32'(fb_data), 32'h0000BB);
        applyStimulus(2, 1'b0, 17'h00200, 24'h0000BB, 1'b0);
        tick();
`endif

        $display("[TB] burst limit on channel 3");
        applyStimulus(3, 1'b1, 17'h00300, 24'h123456, 1'b0);
        tick();
        checkOutput("t3_owner", 32'(owner), 32'd3);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(3, 1'b1, 17'(32'h300 + k), 24'h123456, 1'b0);
            #1;
            checkOutput("t3_ack", 32'(ch_ack), 32'b1000);
            tick();
            checkOutput("t3_addr", 32'(fb_addr), 32'h300 + k);
        end
        applyStimulus(3, 1'b1, 17'h00310, 24'h123456, 1'b0);
        #1;
        checkOutput("t3_busy_limit", 32'(busy), 32'd0);
        checkOutput("t3_ack_limit", 32'(ch_ack), 32'd0);
        tick();
        checkOutput("t3_we_gap", 32'(fb_we), 32'd0);
        checkOutput("t3_regrant", 32'(owner), 32'd3);
        for (int k = 16; k < 20; k++) begin
            applyStimulus(3, 1'b1, 17'(32'h300 + k), 24'h123456, 1'b0);
            #1;
            checkOutput("t3_ack2", 32'(ch_ack), 32'b1000);
            tick();
            checkOutput("t3_addr2", 32'(fb_addr), 32'h300 + k);
        end
        checkOutput("t3_busy_tail", 32'(busy), 32'd1);
        applyStimulus(3, 1'b0, 17'h00313, 24'h123456, 1'b0);
        tick();
        checkOutput("t3_busy_drop", 32'(busy), 32'd0);

`ifndef FB_ARB_ROUND_ROBIN_EN
        $display("[TB] owner drops request");
        applyStimulus(0, 1'b1, 17'h00400, 24'h0F0F0F, 1'b0);
        applyStimulus(1, 1'b1, 17'h00410, 24'hF0F0F0, 1'b1);
        tick();
        checkOutput("t4_owner0", 32'(owner), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1'b1, 17'(32'h400 + k), 24'h0F0F0F, 1'b0);
            #1;
            checkOutput("t4_ack", 32'(ch_ack), 32'b0001);
            tick();
            checkOutput("t4_we", 32'(fb_we), 32'd1);
            checkOutput("t4_addr", 32'(fb_addr), 32'h400 + k);
        end
        applyStimulus(0, 1'b0, 17'h00402, 24'h0F0F0F, 1'b0);
        #1;
        checkOutput("t4_ack_drop", 32'(ch_ack), 32'd0);
        tick();
        checkOutput("t4_busy_idle", 32'(busy), 32'd0);
        checkOutput("t4_we_off", 32'(fb_we), 32'd0);
        tick();
        checkOutput("t4_owner1", 32'(owner), 32'd1);
        checkOutput("t4_ack1", 32'(ch_ack), 32'b0010);
        tick();
        checkOutput("t4_addr1", 32'(fb_addr), 32'h410);
        applyStimulus(1, 1'b0, 17'h00410, 24'hF0F0F0, 1'b0);
        tick();
`endif

        $display("[TB] reset mid-burst");
        applyStimulus(2, 1'b1, 17'h00600, 24'hABCDEF, 1'b0);
        tick();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(2, 1'b1, 17'(32'h600 + k), 24'hABCDEF, 1'b0);
            tick();
        end
        checkOutput("t5_addr7", 32'(fb_addr), 32'h606);
        applyStimulus(2, 1'b1, 17'h00607, 24'hABCDEF, 1'b0);
        #1;
        checkOutput("t5_ack8", 32'(ch_ack), 32'b0100);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_we", 32'(fb_we), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_ack", 32'(ch_ack), 32'd0);
        checkOutput("t5_addr", 32'(fb_addr), 32'd0);
        checkOutput("t5_data", 32'(fb_data), 32'd0);
        applyStimulus(2, 1'b0, 17'h00607, 24'hABCDEF, 1'b0);
        tick();
        checkOutput("t5_we_held", 32'(fb_we), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        checkOutput("t5_busy_after", 32'(busy), 32'd0);
        checkOutput("t5_we_after", 32'(fb_we), 32'd0);

`ifdef FB_ARB_ROUND_ROBIN_EN
        $display("[TB] round-robin order");
        begin
            int exp_order [5] = '{0, 1, 2, 3, 0};
            for (int c = 0; c < NUM_CH; c++)
                applyStimulus(c, 1'b1, 17'(32'h500 + c), 24'(32'h10 * c), 1'b1);
            for (int g = 0; g < 5; g++) begin
                tick();
                checkOutput("rr_owner", 32'(owner), 32'(exp_order[g]));
                checkOutput("rr_ack", 32'(ch_ack), 32'(1 << exp_order[g]));
                tick();
                checkOutput("rr_addr", 32'(fb_addr), 32'h500 + exp_order[g]);
            end
            ch_req = '0;
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
